// File: rtl/pipe_chain.sv
// pipe_chain: elastic register chain with per-stage kill mask and forward compaction.
// Define PIPE_CHAIN_STATS_EN to add handshake and kill counters.
module pipe_chain #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [WIDTH-1:0]           in_data_i,
  input  logic [DEPTH-1:0]           flush_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [WIDTH-1:0]           out_data_o,
  output logic [$clog2(DEPTH+1)-1:0] occupancy_o
`ifdef PIPE_CHAIN_STATS_EN
  ,
  output logic [31:0]                xfer_cnt_o,
  output logic [31:0]                kill_cnt_o
`endif
);
  localparam int OCC_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [DEPTH:0]   free_ext;
  logic [DEPTH-1:0] src_valid, xfer_in, leave;
  logic [WIDTH-1:0] src_data [DEPTH];

  function automatic logic [OCC_W-1:0] popcount(input logic [DEPTH-1:0] v);
    logic [OCC_W-1:0] n;
    n = '0;
    for (int i = 0; i < DEPTH; i++) n = n + OCC_W'(v[i]);
    return n;
  endfunction

  // Each stage's candidate item comes from upstream (stage 0) or the stage behind it.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_src
      if (gi == 0) begin : g_head
        assign src_valid[gi] = in_valid_i;
        assign src_data[gi]  = in_data_i;
      end else begin : g_body
        assign src_valid[gi] = valid_q[gi-1] & ~flush_i[gi-1];
        assign src_data[gi]  = data_q[gi-1];
      end
    end
  endgenerate

  // A stage is free when any bubble (empty, killed, or downstream ready) lies at or ahead of it.
  always_comb begin
    free_ext        = '0;
    free_ext[DEPTH] = out_ready_i;
    for (int k = DEPTH-1; k >= 0; k--) begin
      free_ext[k] = ~valid_q[k] | flush_i[k] | free_ext[k+1];
    end
  end

  always_comb begin
    xfer_in = '0;
    leave   = '0;
    valid_d = '0;
    for (int k = 0; k < DEPTH; k++) begin
      xfer_in[k] = src_valid[k] & free_ext[k];
      leave[k]   = valid_q[k] & ~flush_i[k] & free_ext[k+1];
      valid_d[k] = xfer_in[k] | (valid_q[k] & ~flush_i[k] & ~leave[k]);
      data_d[k]  = xfer_in[k] ? src_data[k] : data_q[k];
    end
    occ_d = popcount(valid_d);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_q <= '0;
      occ_q   <= '0;
      for (int k = 0; k < DEPTH; k++) data_q[k] <= '0;
    end else begin
      valid_q <= valid_d;
      occ_q   <= occ_d;
      for (int k = 0; k < DEPTH; k++) data_q[k] <= data_d[k];
    end
  end

  assign in_ready_o  = free_ext[0] & rst_n_i;
  assign out_valid_o = valid_q[DEPTH-1] & ~flush_i[DEPTH-1];
  assign out_data_o  = data_q[DEPTH-1];
  assign occupancy_o = occ_q;

`ifdef PIPE_CHAIN_STATS_EN
  logic [31:0] xfer_cnt_q, xfer_cnt_d;
  logic [31:0] kill_cnt_q, kill_cnt_d;

  always_comb begin
    xfer_cnt_d = xfer_cnt_q + 32'(out_valid_o & out_ready_i);
    kill_cnt_d = kill_cnt_q + 32'(popcount(valid_q & flush_i));
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      xfer_cnt_q <= '0;
      kill_cnt_q <= '0;
    end else begin
      xfer_cnt_q <= xfer_cnt_d;
      kill_cnt_q <= kill_cnt_d;
    end
  end

  assign xfer_cnt_o = xfer_cnt_q;
  assign kill_cnt_o = kill_cnt_q;
`else
  // statistics counters are not built in this configuration
`endif

endmodule

// File: tb/tb_pipe_chain.sv
// tb_pipe_chain: directed scenarios plus random traffic checked against a slot-level model
// in which a live item advances whenever any gap lies ahead of it.
module tb_pipe_chain;
  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int OW    = $clog2(DEPTH+1);

  logic             clk_i = 1'b0;
  logic             rst_n_i;
  logic             in_valid_i;
  logic             in_ready_o;
  logic [WIDTH-1:0] in_data_i;
  logic [DEPTH-1:0] flush_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [WIDTH-1:0] out_data_o;
  logic [OW-1:0]    occupancy_o;
`ifdef PIPE_CHAIN_STATS_EN
  logic [31:0]      xfer_cnt_o;
  logic [31:0]      kill_cnt_o;
`endif

  pipe_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_data_i),
    .flush_i     (flush_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .occupancy_o (occupancy_o)
`ifdef PIPE_CHAIN_STATS_EN
    ,
    .xfer_cnt_o  (xfer_cnt_o),
    .kill_cnt_o  (kill_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_acc = 0;
  int last_acc_cyc = 0;
  int m_xfer = 0;
  int m_kill = 0;
  bit               m_v [DEPTH];
  logic [WIDTH-1:0] m_d [DEPTH];
  logic [WIDTH-1:0] delivered [$];
  int               deliv_cyc [$];
  logic [WIDTH-1:0] expq [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int m_count();
    int n = 0;
    for (int k = 0; k < DEPTH; k++) n += int'(m_v[k]);
    return n;
  endfunction

  task automatic clear_log();
    delivered.delete();
    deliv_cyc.delete();
    expq.delete();
  endtask

  task automatic check_seq(input string tag);
    logic [WIDTH-1:0] got;
    check({tag, "_count"}, 64'(delivered.size()), 64'(expq.size()));
    for (int i = 0; i < expq.size(); i++) begin
      got = (i < delivered.size()) ? delivered[i] : 'x;
      check(tag, got, expq[i]);
    end
  endtask

  // One clock: drive at the falling edge, check just after, advance the model at the rising edge.
  task automatic step(input bit iv, input logic [WIDTH-1:0] id, input logic [DEPTH-1:0] fl,
                      input bit ordy);
    bit               nv [DEPTH];
    logic [WIDTH-1:0] nd [DEPTH];
    bit               gap;
    bit               exp_ovld;
    in_valid_i  = iv;
    in_data_i   = id;
    flush_i     = fl;
    out_ready_i = ordy;
    #1;
    for (int k = 0; k < DEPTH; k++) begin
      nv[k] = 1'b0;
      nd[k] = m_d[k];
    end
    exp_ovld = m_v[DEPTH-1] && !fl[DEPTH-1];
    gap = ordy;
    for (int k = DEPTH-1; k >= 0; k--) begin
      if (m_v[k] && fl[k]) m_kill++;
      if (m_v[k] && !fl[k]) begin
        if (!gap) nv[k] = 1'b1;
        else if (k < DEPTH-1) begin
          nv[k+1] = 1'b1;
          nd[k+1] = m_d[k];
        end
      end else begin
        gap = 1'b1;
      end
    end
    check("in_ready", 64'(in_ready_o), 64'(gap));
    check("out_valid", 64'(out_valid_o), 64'(exp_ovld));
    if (exp_ovld) check("out_data", 64'(out_data_o), 64'(m_d[DEPTH-1]));
    check("occupancy", 64'(occupancy_o), 64'(m_count()));
    if (exp_ovld && ordy) begin
      delivered.push_back(m_d[DEPTH-1]);
      deliv_cyc.push_back(cyc);
      m_xfer++;
    end
    if (iv && gap) begin
      nv[0] = 1'b1;
      nd[0] = id;
      n_acc++;
      last_acc_cyc = cyc;
    end
    @(posedge clk_i);
    for (int k = 0; k < DEPTH; k++) begin
      m_v[k] = nv[k];
      m_d[k] = nd[k];
    end
    cyc++;
    @(negedge clk_i);
  endtask

  // Asserts reset away from any clock edge, checks the immediate effect, releases at a falling edge.
  task automatic do_reset();
    in_valid_i  = 1'b1;
    out_ready_i = 1'b1;
    flush_i     = '0;
    rst_n_i     = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid_o), 64'd0);
    check("rst_out_data", 64'(out_data_o), 64'd0);
    check("rst_occupancy", 64'(occupancy_o), 64'd0);
    check("rst_in_ready", 64'(in_ready_o), 64'd0);
    for (int k = 0; k < DEPTH; k++) begin
      m_v[k] = 1'b0;
      m_d[k] = '0;
    end
    m_xfer = 0;
    m_kill = 0;
    @(negedge clk_i);
    @(negedge clk_i);
    check("rst_hold_in_ready", 64'(in_ready_o), 64'd0);
`ifdef PIPE_CHAIN_STATS_EN
    check("rst_xfer_cnt", 64'(xfer_cnt_o), 64'd0);
    check("rst_kill_cnt", 64'(kill_cnt_o), 64'd0);
`endif
    rst_n_i = 1'b1;
  endtask

  initial begin
    int c0;
    in_data_i = 32'h1234_5678;
    do_reset();

    // Streaming with no backpressure
    clear_log();
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 32'h11 + 32'(i), '0, 1'b1);
      if (i == 0) c0 = last_acc_cyc;
    end
    for (int i = 0; i < 6; i++) step(1'b0, '0, '0, 1'b1);
    for (int i = 0; i < 8; i++) expq.push_back(32'h11 + 32'(i));
    check_seq("stream_order");
    if (deliv_cyc.size() == 8) begin
      check("stream_latency", 64'(deliv_cyc[0] - c0), 64'(DEPTH));
      for (int i = 1; i < 8; i++) check("stream_rate", 64'(deliv_cyc[i] - deliv_cyc[i-1]), 64'd1);
    end

    // Backpressure: chain fills then stalls
    clear_log();
    n_acc = 0;
    for (int i = 0; i < 10; i++) step(1'b1, 32'h21 + 32'(i), '0, 1'b0);
    check("bp_accepted", 64'(n_acc), 64'd4);
    check("bp_in_ready", 64'(in_ready_o), 64'd0);
    check("bp_occupancy", 64'(occupancy_o), 64'd4);
    for (int i = 0; i < 6; i++) step(1'b0, '0, '0, 1'b1);
    for (int i = 0; i < 4; i++) expq.push_back(32'h21 + 32'(i));
    check_seq("bp_order");

    // Flush middle stages of a full chain: D in stage 3 ... A in stage 0
    clear_log();
    step(1'b1, 32'hD4, '0, 1'b0);
    step(1'b1, 32'hC3, '0, 1'b0);
    step(1'b1, 32'hB2, '0, 1'b0);
    step(1'b1, 32'hA1, '0, 1'b0);
    check("flush_pre_occ", 64'(occupancy_o), 64'd4);
    step(1'b0, '0, 4'b0110, 1'b0);
    check("flush_post_occ", 64'(occupancy_o), 64'd2);
    for (int i = 0; i < 6; i++) step(1'b0, '0, '0, 1'b1);
    expq.push_back(32'hD4);
    expq.push_back(32'hA1);
    check_seq("flush_order");

    // Flush stage 2 while stage 1 moves X into it
    clear_log();
    step(1'b1, 32'h50, '0, 1'b0);
    step(1'b1, 32'h6B, '0, 1'b0);
    step(1'b1, 32'h7C, '0, 1'b0);
    step(1'b0, '0, '0, 1'b0);
    check("refill_pre_occ", 64'(occupancy_o), 64'd3);
    step(1'b0, '0, 4'b0100, 1'b0);
    check("refill_post_occ", 64'(occupancy_o), 64'd2);
    for (int i = 0; i < 6; i++) step(1'b0, '0, '0, 1'b1);
    expq.push_back(32'h50);
    expq.push_back(32'h7C);
    check_seq("refill_order");

    // Reset with three items in flight
    clear_log();
    step(1'b1, 32'h91, '0, 1'b0);
    step(1'b1, 32'h92, '0, 1'b0);
    step(1'b1, 32'h93, '0, 1'b0);
    step(1'b0, '0, '0, 1'b0);
    #2;
    do_reset();
    clear_log();
    step(1'b1, 32'h5A, '0, 1'b1);
    c0 = last_acc_cyc;
    for (int i = 0; i < 6; i++) step(1'b0, '0, '0, 1'b1);
    expq.push_back(32'h5A);
    check_seq("rst_resume");
    if (deliv_cyc.size() == 1) check("rst_resume_latency", 64'(deliv_cyc[0] - c0), 64'(DEPTH));

    // Statistics: 6 delivered, 2 killed
    #2;
    do_reset();
    clear_log();
    for (int i = 0; i < 4; i++) step(1'b1, 32'h61 + 32'(i), '0, 1'b0);
    step(1'b0, '0, 4'b0011, 1'b0);
    for (int i = 4; i < 8; i++) step(1'b1, 32'h61 + 32'(i), '0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, '0, '0, 1'b1);
    expq.push_back(32'h61);
    expq.push_back(32'h62);
    for (int i = 4; i < 8; i++) expq.push_back(32'h61 + 32'(i));
    check_seq("stats_order");
`ifdef PIPE_CHAIN_STATS_EN
    check("stats_xfer", 64'(xfer_cnt_o), 64'd6);
    check("stats_kill", 64'(kill_cnt_o), 64'd2);
`endif

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [DEPTH-1:0] fl;
      fl = (($urandom % 6) == 0) ? DEPTH'($urandom) : '0;
      step(($urandom % 4) != 0, $urandom, fl, ($urandom % 3) != 0);
    end
`ifdef PIPE_CHAIN_STATS_EN
    check("rand_xfer", 64'(xfer_cnt_o), 64'(m_xfer));
    check("rand_kill", 64'(kill_cnt_o), 64'(m_kill));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
